// File: rtl/mux8_way.sv
// Registered 8-to-1 multiplexer with valid qualifier and select echo.
// All outputs come straight from flops; reset is synchronous, active-low.
module mux8_way #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in0,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [2:0]       out_sel
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_sel_q, out_sel_d;

  // Data and select echo hold when nothing is captured; only valid drops.
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      out_sel_d   = sel;
      unique case (sel)
        3'd0: out_d = in0;
        3'd1: out_d = in1;
        3'd2: out_d = in2;
        3'd3: out_d = in3;
        3'd4: out_d = in4;
        3'd5: out_d = in5;
        3'd6: out_d = in6;
        3'd7: out_d = in7;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8_way.sv
// Scoreboard bench for mux8_way: one WIDTH=8 and one WIDTH=1 instance share stimulus;
// expected responses are queued at each capture edge and popped by a negedge monitor.
module tb_mux8_way;

  typedef struct {
    logic [7:0] o8;
    logic       o1;
    logic [2:0] s;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_in [8];
  logic [2:0] sel;
  logic       in_valid;

  logic [7:0] out8;
  logic       out_valid8;
  logic [2:0] out_sel8;
  logic [0:0] out1;
  logic       out_valid1;
  logic [2:0] out_sel1;

  exp_t       sb_q [$];
  exp_t       model;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux8_way #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in7(d_in[7]), .in6(d_in[6]), .in5(d_in[5]), .in4(d_in[4]),
    .in3(d_in[3]), .in2(d_in[2]), .in1(d_in[1]), .in0(d_in[0]),
    .sel(sel), .in_valid(in_valid),
    .out(out8), .out_valid(out_valid8), .out_sel(out_sel8)
  );

  mux8_way #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in7(d_in[7][0]), .in6(d_in[6][0]), .in5(d_in[5][0]), .in4(d_in[4][0]),
    .in3(d_in[3][0]), .in2(d_in[2][0]), .in1(d_in[1][0]), .in0(d_in[0][0]),
    .sel(sel), .in_valid(in_valid),
    .out(out1), .out_valid(out_valid1), .out_sel(out_sel1)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus, then record what the spec says the outputs become.
  task automatic step(input logic r, input logic v, input logic [2:0] s);
    rst_n    = r;
    in_valid = v;
    sel      = s;
    @(posedge clk);
    if (!r) begin
      model.o8 = 8'h00; model.o1 = 1'b0; model.s = 3'd0; model.v = 1'b0;
    end else if (v) begin
      model.o8 = d_in[s];
      model.o1 = d_in[s][0];
      model.s  = s;
      model.v  = 1'b1;
    end else begin
      model.v  = 1'b0;
    end
    sb_q.push_back(model);
    #1;
  endtask

  task automatic fill(input logic [7:0] base, input logic inc);
    for (int j = 0; j < 8; j++) d_in[j] = inc ? base + 8'(j) : base;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("out8",       out8,               e.o8);
        chk("out_valid8", {7'b0, out_valid8}, {7'b0, e.v});
        chk("out_sel8",   {5'b0, out_sel8},   {5'b0, e.s});
        chk("out1",       {7'b0, out1},       {7'b0, e.o1});
        chk("out_valid1", {7'b0, out_valid1}, {7'b0, e.v});
        chk("out_sel1",   {5'b0, out_sel1},   {5'b0, e.s});
      end
    end
  end

  initial begin : stimulus
    model = '{o8: 8'h00, o1: 1'b0, s: 3'd0, v: 1'b0};
    fill(8'h00, 1'b0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd3);

    // one-hot walk
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) d_in[j] = (j == k) ? 8'h01 : 8'h00;
      step(1'b1, 1'b1, 3'(k));
    end

    // inverse walk: selected input is the only zero
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) d_in[j] = (j == k) ? 8'h00 : 8'hFF;
      step(1'b1, 1'b1, 3'(k));
    end

    // mismatched select
    fill(8'h00, 1'b0);
    d_in[0] = 8'h01;
    step(1'b1, 1'b1, 3'd7);
    step(1'b1, 1'b1, 3'd0);

    // hold with toggling inputs
    fill(8'h00, 1'b0);
    d_in[5] = 8'hA5;
    step(1'b1, 1'b1, 3'd5);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 8; j++) d_in[j] = 8'($urandom);
      step(1'b1, 1'b0, 3'($urandom));
    end

    // reset while a word is offered, then recapture
    fill(8'hFF, 1'b0);
    step(1'b1, 1'b1, 3'd2);
    step(1'b0, 1'b1, 3'd6);
    step(1'b1, 1'b0, 3'd1);
    d_in[4] = 8'h3C;
    step(1'b1, 1'b1, 3'd4);

    // back-to-back sweep over 8'h10..8'h17
    fill(8'h10, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 3'(k));

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 8; j++) d_in[j] = 8'($urandom);
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 3'($urandom));
    end

    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_way.md
Name: mux8_way

Overview:
- Registered 8-to-1 multiplexer.
- Eight data inputs of parameterisable width; a 3-bit select picks one of them, and the selected word is captured into an output register on the clock edge.
- Used as a generic selection primitive in the datapath, for example for register-file read ports and ALU operand selection.
- Provides a valid qualifier and a select echo so downstream logic can track which source was captured.

Parameters:
- WIDTH, 1, bit width of each data input and of out.

Ports:
- clk, input, 1, rising-edge clock. Single clock domain.
- rst_n, input, 1, reset: synchronous, active-low.
- in7, input, WIDTH, data source 7, selected when sel = 3'b111.
- in6, input, WIDTH, data source 6, selected when sel = 3'b110.
- in5, input, WIDTH, data source 5, selected when sel = 3'b101.
- in4, input, WIDTH, data source 4, selected when sel = 3'b100.
- in3, input, WIDTH, data source 3, selected when sel = 3'b011.
- in2, input, WIDTH, data source 2, selected when sel = 3'b010.
- in1, input, WIDTH, data source 1, selected when sel = 3'b001.
- in0, input, WIDTH, data source 0, selected when sel = 3'b000.
- sel, input, 3, source select (binary index).
- in_valid, input, 1, qualifies in0..in7 and sel for capture this cycle.
- out, output, WIDTH, registered selected data.
- out_valid, output, 1, out holds a word captured on the previous edge.
- out_sel, output, 3, registered copy of sel for the word in out.

Behaviour:
- Port order is fixed as: clk, rst_n, in7..in0, sel, in_valid, out, out_valid, out_sel.
- Selection is a pure index: out_next = in[sel], where in[k] is ink. No priority logic; all 8 codes are legal. There is no X or default path.
- On a rising clk edge with rst_n = 0: out <= 0, out_valid <= 0, out_sel <= 3'b000. Reset takes precedence over in_valid.
- On a rising clk edge with rst_n = 1 and in_valid = 1: out <= in[sel], out_sel <= sel, out_valid <= 1.
- On a rising clk edge with rst_n = 1 and in_valid = 0: out and out_sel hold their previous values; out_valid <= 0.
- Latency: exactly 1 clock from input sampling to out. Throughput is one selection per cycle; back-to-back in_valid is supported with no bubbles.
- Non-selected inputs have no effect on out, including X or toggling values.
- WIDTH > 1: all bits of the selected word pass through unchanged, with no bit reordering.
- Reset mid-stream: a word presented in the same cycle that rst_n = 0 is dropped. The first capture after reset release happens on the first edge with rst_n = 1 and in_valid = 1.
- Outputs are driven only by flops; there is no combinational path from any input to any output.

Test Plan:
- One-hot walk, WIDTH = 1, in_valid = 1: for k = 0..7 drive in{7..0} = 1 << k with sel = k. Required: out = 1 and out_sel = k one cycle later, out_valid = 1 throughout.
- Inverse walk: drive all inputs 1 except ink = 0, with sel = k for k = 0..7. Required: out = 0 one cycle later, proving non-selected inputs are ignored.
- Mismatched select: drive in{7..0} = 8'b00000001 with sel = 3'b111. Required: out = 0. Then sel = 3'b000. Required: out = 1.
- Hold: capture in5 = 1 with sel = 5, then drop in_valid and toggle all inputs and sel. Required: out stays 1, out_sel stays 5, out_valid = 0.
- Reset: with out = 1 and out_valid = 1, assert rst_n = 0 for one edge while in_valid = 1. Required: out = 0, out_valid = 0, out_sel = 0. After release, a new capture works on the next in_valid edge.
- WIDTH = 8: load in0..in7 = 8'h10..8'h17 and sweep sel 0..7 back-to-back. Required: out follows 8'h10..8'h17 with 1-cycle lag and no gaps.
